param_control_unit: RTL and testbench
=====================================

Name: param_control_unit

Overview:
- Next-generation Moore-style multicycle control sequencer for the Mini SRC datapath.
- Fetches and decodes the 5-bit opcode in IR[DATA_W-1 -: 5] and steps through per-instruction control states.
- Adds four things over the fixed-timing sequencer: variable-latency memory and mul/div handshakes, a memory-timeout/illegal-opcode trap, Stop/Resume at instruction boundaries, and an instruction counter.
- Control fields are packed into one-hot vectors so that datapath width and register count are parameters.

Parameters:
DATA_W, 32, IR/datapath width
NUM_REGS, 16, general registers (width of R_enableIn)
LINK_REG, 14, register written with the return PC by jal
MAX_WAIT, 15, memory wait cycles before trap; 0 = wait forever
CNT_W, 32, Instr_count width

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-low reset
IR  in  DATA_W  instruction register contents
Mem_ready  in  1  memory completes the current request this cycle
ALU_busy  in  1  multicycle mul/div still running
Con_ff  in  1  branch condition flip-flop
Stop  in  1  halt request, honoured at an instruction boundary
Resume  in  1  leave HALT
Bus_sel  out  10  one-hot bus driver [0]PC [1]MDR [2]ZHigh [3]ZLow [4]HI [5]LO [6]InPort [7]C [8]Rout [9]BAout; all zero = bus idle
Ld_en  out  10  load enables [0]MAR [1]MDR [2]IR [3]PC [4]Y [5]Z [6]HI [7]LO [8]R(selected) [9]OutPort
Reg_sel  out  3  one-hot [0]Gra [1]Grb [2]Grc
R_enableIn  out  NUM_REGS  direct register write enable (jal only)
MDR_read, IncPC, CON_enable, Alu_start  out  1 each  datapath strobes
Mem_req, Mem_write  out  1 each  memory handshake
Run  out  1  high when executing
Trap  out  1  high in TRAP
Trap_cause  out  2  01 illegal opcode, 10 memory timeout; held until Reset
Instr_count  out  CNT_W  fetched-instruction count

Behaviour:
- Reset=0 at a rising edge: state goes to RESET; all outputs 0; Instr_count=0; Trap_cause=0. Reset overrides every other input and aborts any request in progress; Mem_req drops after that edge.
- Outputs decode from the state register (Moore). Any output not listed for a state is 0. Run=1 in every state except RESET, HALT and TRAP.
- RESET always goes to F0.
- Fetch sequence:
  - F0: Bus_sel PC, Ld MAR.
  - F1: Mem_req, MDR_read, Ld MDR. Hold F1 until Mem_ready=1.
  - F2: Bus MDR, Ld IR, Ld PC, IncPC.
  - DEC: no outputs; Instr_count+1, wrapping modulo 2^CNT_W.
- Memory wait counter:
  - Cleared on entry to any wait state and incremented each cycle that Mem_ready=0.
  - Mem_ready=1 on the entry cycle means zero wait states.
  - Counter==MAX_WAIT with Mem_ready=0 (and MAX_WAIT≠0) goes to TRAP with cause 10.
- Opcodes and execute steps E1..:
  - ALU register (add 00011, sub 00100, shr 00101, shra 00110, shl 00111, ror 01000, rol 01001, and 01010, or 01011):
    - E1: Grb, Rout, Ld Y.
    - E2: Grc, Rout, Ld Z.
    - E3: ZLow, Gra, Ld R.
  - ALU immediate (addi 01100, andi 01101, ori 01110): same as ALU register, except E2 drives C instead of Grc/Rout.
  - neg 10001 / not 10010:
    - E1: Grb, Rout, Ld Z.
    - E2: ZLow, Gra, Ld R.
  - mul 01111 / div 10000:
    - E1: Grb, Rout, Ld Y.
    - E2: Grc, Rout, Ld Z, Alu_start. Alu_start is asserted only on the first E2 cycle.
    - Stay in E2 while ALU_busy=1.
    - E3: ZLow, Ld LO.
    - E4: ZHigh, Ld HI.
  - ld 00000:
    - E1: Grb, BAout, Ld Y.
    - E2: C, Ld Z.
    - E3: ZLow, Ld MAR.
    - E4: Mem_req, MDR_read, Ld MDR; wait for Mem_ready.
    - E5: MDR, Gra, Ld R.
  - ldi 00001: E1–E2 as ld; E3: ZLow, Gra, Ld R.
  - st 00010:
    - E1–E3 as ld.
    - E4: Gra, Rout, Ld MDR (MDR_read=0).
    - E5: Mem_req, Mem_write; wait for Mem_ready.
  - br 10011:
    - E1: Gra, Rout, CON_enable.
    - E2: PC, Ld Y.
    - E3: C, Ld Z.
    - E4: ZLow, Ld PC only if Con_ff=1; otherwise no outputs.
  - jr 10100: E1: Gra, Rout, Ld PC.
  - jal 10101:
    - E1: PC on bus, R_enableIn[LINK_REG]=1.
    - E2: Gra, Rout, Ld PC.
  - mfhi 11000 / mflo 11001: E1: HI or LO, Gra, Ld R.
  - in 10110: E1: InPort, Gra, Ld R.
  - out 10111: E1: Gra, Rout, Ld OutPort.
  - nop 11010: one empty E1.
  - halt 11011: go to HALT.
  - 11100–11111: TRAP with cause 01.
- Instruction boundary = the last execute step. From it, Stop=1 goes to HALT; otherwise F0. Stop at any other time is ignored until the boundary.
- HALT: Resume=1 and Stop=0 goes to F0. Stop=1 keeps HALT (Stop wins over Resume).
- TRAP: exits only via Reset.

Test Plan:
- add R3,R1,R2 with Mem_ready tied 1 → F0,F1,F2,DEC,E1..E3 = 7 cycles; E3 Bus_sel=0x008, Ld_en=0x100, Reg_sel=001; Instr_count=1.
- ld with Mem_ready delayed 3 cycles in both F1 and E4 → each wait state held exactly 4 cycles; E5 Bus_sel=0x002; no trap.
- Mem_ready held 0, MAX_WAIT=15 → TRAP after 16 F1 cycles; Trap=1, Trap_cause=10, Run=0; Reset=0 clears to RESET, then F0.
- mul with ALU_busy high 5 cycles → Alu_start a single pulse; E2 held 6 cycles; then Ld LO followed by Ld HI.
- br with Con_ff=0, then Con_ff=1 → no Ld PC vs. Ld_en=0x008 in E4; jal → R_enableIn=0x4000 in E1; opcode 11101 → Trap_cause=01.
- Stop pulsed mid-add → add completes, then HALT; Resume with Stop=1 stays HALT; Resume alone → F0; Reset=0 during E4 of st → Mem_write=0 next cycle, state RESET.

Source files
------------

// File: rtl/param_control_unit.sv
// Moore multicycle control sequencer for the Mini SRC datapath, with memory/mul-div
// handshakes, timeout and illegal-opcode trap, Stop/Resume and an instruction counter.
module param_control_unit #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int LINK_REG = 14,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [DATA_W-1:0]   IR,
    input  logic                Mem_ready,
    input  logic                ALU_busy,
    input  logic                Con_ff,
    input  logic                Stop,
    input  logic                Resume,
    output logic [9:0]          Bus_sel,
    output logic [9:0]          Ld_en,
    output logic [2:0]          Reg_sel,
    output logic [NUM_REGS-1:0] R_enableIn,
    output logic                MDR_read,
    output logic                IncPC,
    output logic                CON_enable,
    output logic                Alu_start,
    output logic                Mem_req,
    output logic                Mem_write,
    output logic                Run,
    output logic                Trap,
    output logic [1:0]          Trap_cause,
    output logic [CNT_W-1:0]    Instr_count
);
    localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    localparam int B_PC = 0, B_MDR = 1, B_ZH = 2, B_ZL = 3, B_HI = 4;
    localparam int B_LO = 5, B_IN = 6, B_C = 7, B_ROUT = 8, B_BA = 9;
    localparam int L_MAR = 0, L_MDR = 1, L_IR = 2, L_PC = 3, L_Y = 4;
    localparam int L_Z = 5, L_HI = 6, L_LO = 7, L_R = 8, L_OUT = 9;
    localparam int G_A = 0, G_B = 1, G_C = 2;

    typedef enum logic [3:0] {
        S_RESET, S_F0, S_F1, S_F2, S_DEC,
        S_E1, S_E2, S_E3, S_E4, S_E5, S_HALT, S_TRAP
    } state_t;

    typedef enum logic [4:0] {
        C_ALU, C_IMM, C_UN, C_MUL, C_LD, C_LDI, C_ST, C_BR, C_JR,
        C_JAL, C_HI, C_LO, C_IN, C_OUT, C_NOP, C_HALT, C_ILL
    } cls_t;

    typedef struct packed {
        logic [9:0] bus;
        logic [9:0] ld;
        logic [2:0] rs;
        logic       link;
        logic       mdr_read;
        logic       incpc;
        logic       con_en;
        logic       mem_req;
        logic       mem_write;
        logic       run;
        logic       trap;
    } ctl_t;

    function automatic cls_t classify(input logic [4:0] op);
        case (op) inside
            5'b00000:            return C_LD;
            5'b00001:            return C_LDI;
            5'b00010:            return C_ST;
            [5'b00011:5'b01011]: return C_ALU;
            [5'b01100:5'b01110]: return C_IMM;
            5'b01111, 5'b10000:  return C_MUL;
            5'b10001, 5'b10010:  return C_UN;
            5'b10011:            return C_BR;
            5'b10100:            return C_JR;
            5'b10101:            return C_JAL;
            5'b10110:            return C_IN;
            5'b10111:            return C_OUT;
            5'b11000:            return C_HI;
            5'b11001:            return C_LO;
            5'b11010:            return C_NOP;
            5'b11011:            return C_HALT;
            default:             return C_ILL;
        endcase
    endfunction

    function automatic logic [2:0] last_step(input cls_t c);
        case (c)
            C_ALU, C_IMM, C_LDI: return 3'd3;
            C_UN, C_JAL:         return 3'd2;
            C_MUL, C_BR:         return 3'd4;
            C_LD, C_ST:          return 3'd5;
            default:             return 3'd1;
        endcase
    endfunction

    function automatic logic [2:0] step_of(input state_t s);
        case (s)
            S_E1:    return 3'd1;
            S_E2:    return 3'd2;
            S_E3:    return 3'd3;
            S_E4:    return 3'd4;
            S_E5:    return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic state_t step_state(input logic [2:0] n);
        case (n)
            3'd1:    return S_E1;
            3'd2:    return S_E2;
            3'd3:    return S_E3;
            3'd4:    return S_E4;
            default: return S_E5;
        endcase
    endfunction

    function automatic ctl_t decode(input state_t s, input cls_t c, input logic con);
        ctl_t o;
        o      = '0;
        o.run  = !(s inside {S_RESET, S_HALT, S_TRAP});
        o.trap = (s == S_TRAP);
        case (s)
            S_F0: begin o.bus[B_PC] = 1'b1; o.ld[L_MAR] = 1'b1; end
            S_F1: begin o.mem_req = 1'b1; o.mdr_read = 1'b1; o.ld[L_MDR] = 1'b1; end
            S_F2: begin
                o.bus[B_MDR] = 1'b1; o.ld[L_IR] = 1'b1; o.ld[L_PC] = 1'b1; o.incpc = 1'b1;
            end
            S_E1: case (c)
                C_ALU, C_IMM, C_MUL: begin o.bus[B_ROUT] = 1'b1; o.rs[G_B] = 1'b1; o.ld[L_Y] = 1'b1; end
                C_UN:  begin o.bus[B_ROUT] = 1'b1; o.rs[G_B] = 1'b1; o.ld[L_Z] = 1'b1; end
                C_LD, C_LDI, C_ST: begin o.bus[B_BA] = 1'b1; o.rs[G_B] = 1'b1; o.ld[L_Y] = 1'b1; end
                C_BR:  begin o.bus[B_ROUT] = 1'b1; o.rs[G_A] = 1'b1; o.con_en = 1'b1; end
                C_JR:  begin o.bus[B_ROUT] = 1'b1; o.rs[G_A] = 1'b1; o.ld[L_PC] = 1'b1; end
                C_JAL: begin o.bus[B_PC] = 1'b1; o.link = 1'b1; end
                C_HI:  begin o.bus[B_HI] = 1'b1; o.rs[G_A] = 1'b1; o.ld[L_R] = 1'b1; end
                C_LO:  begin o.bus[B_LO] = 1'b1; o.rs[G_A] = 1'b1; o.ld[L_R] = 1'b1; end
                C_IN:  begin o.bus[B_IN] = 1'b1; o.rs[G_A] = 1'b1; o.ld[L_R] = 1'b1; end
                C_OUT: begin o.bus[B_ROUT] = 1'b1; o.rs[G_A] = 1'b1; o.ld[L_OUT] = 1'b1; end
                default: ;
            endcase
            S_E2: case (c)
                C_ALU, C_MUL: begin o.bus[B_ROUT] = 1'b1; o.rs[G_C] = 1'b1; o.ld[L_Z] = 1'b1; end
                C_IMM, C_LD, C_LDI, C_ST: begin o.bus[B_C] = 1'b1; o.ld[L_Z] = 1'b1; end
                C_UN:  begin o.bus[B_ZL] = 1'b1; o.rs[G_A] = 1'b1; o.ld[L_R] = 1'b1; end
                C_BR:  begin o.bus[B_PC] = 1'b1; o.ld[L_Y] = 1'b1; end
                C_JAL: begin o.bus[B_ROUT] = 1'b1; o.rs[G_A] = 1'b1; o.ld[L_PC] = 1'b1; end
                default: ;
            endcase
            S_E3: case (c)
                C_ALU, C_IMM, C_LDI: begin o.bus[B_ZL] = 1'b1; o.rs[G_A] = 1'b1; o.ld[L_R] = 1'b1; end
                C_MUL:       begin o.bus[B_ZL] = 1'b1; o.ld[L_LO] = 1'b1; end
                C_LD, C_ST:  begin o.bus[B_ZL] = 1'b1; o.ld[L_MAR] = 1'b1; end
                C_BR:        begin o.bus[B_C] = 1'b1; o.ld[L_Z] = 1'b1; end
                default: ;
            endcase
            S_E4: case (c)
                C_MUL: begin o.bus[B_ZH] = 1'b1; o.ld[L_HI] = 1'b1; end
                C_LD:  begin o.mem_req = 1'b1; o.mdr_read = 1'b1; o.ld[L_MDR] = 1'b1; end
                C_ST:  begin o.bus[B_ROUT] = 1'b1; o.rs[G_A] = 1'b1; o.ld[L_MDR] = 1'b1; end
                C_BR:  if (con) begin o.bus[B_ZL] = 1'b1; o.ld[L_PC] = 1'b1; end
                default: ;
            endcase
            S_E5: case (c)
                C_LD: begin o.bus[B_MDR] = 1'b1; o.rs[G_A] = 1'b1; o.ld[L_R] = 1'b1; end
                C_ST: begin o.mem_req = 1'b1; o.mem_write = 1'b1; end
                default: ;
            endcase
            default: ;
        endcase
        return o;
    endfunction

    state_t           state, nxt;
    ctl_t             ctl;
    logic             alu_start_q, stop_pend, wait_st, timeout, hold;
    logic [WW-1:0]    wcnt;
    logic [1:0]       cause_q, cause_nxt;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       op_q, op_use;
    cls_t             cls;
    logic             unused_ir;

    assign unused_ir = ^IR[DATA_W-6:0];
    // The opcode is taken live from IR while decoding, then held for the execute steps.
    assign op_use  = (state == S_DEC) ? IR[DATA_W-1 -: 5] : op_q;
    assign cls     = classify(op_use);
    assign wait_st = (state == S_F1) || (state == S_E4 && cls == C_LD) || (state == S_E5 && cls == C_ST);
    assign timeout = (MAX_WAIT != 0) && (wcnt == WW'(MAX_WAIT));

    always_comb begin
        nxt       = state;
        cause_nxt = 2'b00;
        hold      = 1'b0;
        case (state)
            S_RESET: nxt = S_F0;
            S_F0:    nxt = S_F1;
            S_F2:    nxt = S_DEC;
            S_DEC: begin
                if (cls == C_ILL) begin
                    nxt = S_TRAP; cause_nxt = 2'b01;
                end else if (cls == C_HALT) nxt = S_HALT;
                else nxt = S_E1;
            end
            S_HALT: if (Resume && !Stop) nxt = S_F0;
            S_TRAP: ;
            default: begin
                if (wait_st && !Mem_ready) begin
                    hold = 1'b1;
                    if (timeout) begin nxt = S_TRAP; cause_nxt = 2'b10; end
                end else if (state == S_E2 && cls == C_MUL && ALU_busy) hold = 1'b1;
                if (!hold) begin
                    if (state == S_F1) nxt = S_F2;
                    else if (step_of(state) == last_step(cls)) nxt = (Stop || stop_pend) ? S_HALT : S_F0;
                    else nxt = step_state(step_of(state) + 3'd1);
                end
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state register.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state       <= S_RESET;
            ctl         <= '0;
            alu_start_q <= 1'b0;
            wcnt        <= '0;
            stop_pend   <= 1'b0;
            cause_q     <= 2'b00;
            cnt         <= '0;
        end else begin
            state       <= nxt;
            ctl         <= decode(nxt, cls, Con_ff);
            alu_start_q <= (state == S_E1) && (cls == C_MUL);
            wcnt        <= (wait_st && !Mem_ready) ? wcnt + 1'b1 : '0;
            stop_pend   <= (nxt == S_HALT) ? 1'b0 : (stop_pend | Stop);
            if (nxt == S_TRAP && state != S_TRAP) cause_q <= cause_nxt;
            if (state == S_DEC) cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        op_q <= op_use;
    end

    assign Bus_sel     = ctl.bus;
    assign Ld_en       = ctl.ld;
    assign Reg_sel     = ctl.rs;
    assign R_enableIn  = ctl.link ? (NUM_REGS'(1) << LINK_REG) : '0;
    assign MDR_read    = ctl.mdr_read;
    assign IncPC       = ctl.incpc;
    assign CON_enable  = ctl.con_en;
    assign Alu_start   = alu_start_q;
    assign Mem_req     = ctl.mem_req;
    assign Mem_write   = ctl.mem_write;
    assign Run         = ctl.run;
    assign Trap        = ctl.trap;
    assign Trap_cause  = cause_q;
    assign Instr_count = cnt;
endmodule

// File: tb/tb_param_control_unit.sv
// Scoreboard bench for param_control_unit: directed instruction sequences push
// per-cycle expected control vectors; a negedge monitor pops and compares them.
module tb_param_control_unit;
    logic        Clock = 1'b0;
    logic        Reset, Mem_ready, ALU_busy, Con_ff, Stop, Resume;
    logic [31:0] IR;
    logic [9:0]  Bus_sel, Ld_en;
    logic [2:0]  Reg_sel;
    logic [15:0] R_enableIn;
    logic        MDR_read, IncPC, CON_enable, Alu_start, Mem_req, Mem_write, Run, Trap;
    logic [1:0]  Trap_cause;
    logic [31:0] Instr_count;

    param_control_unit dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .Mem_ready(Mem_ready), .ALU_busy(ALU_busy),
        .Con_ff(Con_ff), .Stop(Stop), .Resume(Resume), .Bus_sel(Bus_sel), .Ld_en(Ld_en),
        .Reg_sel(Reg_sel), .R_enableIn(R_enableIn), .MDR_read(MDR_read), .IncPC(IncPC),
        .CON_enable(CON_enable), .Alu_start(Alu_start), .Mem_req(Mem_req), .Mem_write(Mem_write),
        .Run(Run), .Trap(Trap), .Trap_cause(Trap_cause), .Instr_count(Instr_count)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int          cyc;
        string       nm;
        logic [32:0] v;
        bit          chk_ren;
        logic [15:0] ren;
        bit          chk_cnt;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   cyc_n = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;

    always @(posedge Clock) cyc_n <= cyc_n + 1;

    // {bus, ld, reg_sel, {MDR_read,IncPC,CON_enable,Alu_start,Mem_req,Mem_write}, Run, Trap, cause}
    function automatic logic [32:0] mk(input logic [9:0] b, input logic [9:0] l, input logic [2:0] r,
                                       input logic [5:0] s, input logic run, input logic trp,
                                       input logic [1:0] cause);
        return {b, l, r, s, run, trp, cause};
    endfunction

    function automatic logic [32:0] obs();
        return {Bus_sel, Ld_en, Reg_sel, MDR_read, IncPC, CON_enable, Alu_start,
                Mem_req, Mem_write, Run, Trap, Trap_cause};
    endfunction

    always @(negedge Clock) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc_n) begin
            e = q.pop_front();
            n_tests++;
            if (e.cyc != cyc_n) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.nm, e.cyc, cyc_n);
            end else if (obs() != e.v || (e.chk_ren && R_enableIn != e.ren) ||
                         (e.chk_cnt && Instr_count != e.cnt)) begin
                n_fail++;
                $display("FAIL %s cyc=%0d: got ctl=%h ren=%h cnt=%0d, expected ctl=%h ren=%h cnt=%0d",
                         e.nm, cyc_n, obs(), R_enableIn, Instr_count, e.v,
                         e.chk_ren ? e.ren : R_enableIn, e.chk_cnt ? e.cnt : Instr_count);
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push(input string nm, input logic [32:0] v, input bit cr = 0,
                        input logic [15:0] ren = 0, input bit cc = 0, input logic [31:0] cnt = 0);
        exp_t e;
        e.cyc = cyc_n; e.nm = nm; e.v = v;
        e.chk_ren = cr; e.ren = ren; e.chk_cnt = cc; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic ex(input string nm, input logic [9:0] b, input logic [9:0] l,
                      input logic [2:0] r, input logic [5:0] s);
        tick();
        push(nm, mk(b, l, r, s, 1'b1, 1'b0, 2'b00));
    endtask

    task automatic fetch(input string nm, input logic [4:0] op, input int nwait);
        IR = {op, 27'h1234567};
        Mem_ready = 1'b1;
        ex({nm, "_f0"}, 10'h001, 10'h001, 3'b000, 6'b000000);
        ex({nm, "_f1"}, 10'h000, 10'h002, 3'b000, 6'b100010);
        for (int i = 0; i < nwait; i++) begin
            Mem_ready = 1'b0;
            ex({nm, "_f1w"}, 10'h000, 10'h002, 3'b000, 6'b100010);
        end
        Mem_ready = 1'b1;
        ex({nm, "_f2"}, 10'h002, 10'h00C, 3'b000, 6'b010000);
        tick();
        push({nm, "_dec"}, mk(0, 0, 0, 0, 1'b1, 1'b0, 2'b00), 0, 0, 1, exp_cnt);
        exp_cnt++;
    endtask

    initial begin
        Reset = 1'b0; IR = '0; Mem_ready = 1'b1; ALU_busy = 1'b0;
        Con_ff = 1'b0; Stop = 1'b0; Resume = 1'b0;
        tick(); tick();
        push("reset", mk(0, 0, 0, 0, 1'b0, 1'b0, 2'b00), 1, 16'h0, 1, 0);
        Reset = 1'b1;

        fetch("add", 5'b00011, 0);
        ex("add_e1", 10'h100, 10'h010, 3'b010, 6'b0);
        ex("add_e2", 10'h100, 10'h020, 3'b100, 6'b0);
        ex("add_e3", 10'h008, 10'h100, 3'b001, 6'b0);

        fetch("ld", 5'b00000, 3);
        ex("ld_e1", 10'h200, 10'h010, 3'b010, 6'b0);
        ex("ld_e2", 10'h080, 10'h020, 3'b000, 6'b0);
        ex("ld_e3", 10'h008, 10'h001, 3'b000, 6'b0);
        ex("ld_e4", 10'h000, 10'h002, 3'b000, 6'b100010);
        for (int i = 0; i < 3; i++) begin
            Mem_ready = 1'b0;
            ex("ld_e4w", 10'h000, 10'h002, 3'b000, 6'b100010);
        end
        Mem_ready = 1'b1;
        ex("ld_e5", 10'h002, 10'h100, 3'b001, 6'b0);

        fetch("mul", 5'b01111, 0);
        ex("mul_e1", 10'h100, 10'h010, 3'b010, 6'b0);
        ex("mul_e2_start", 10'h100, 10'h020, 3'b100, 6'b000100);
        for (int i = 0; i < 5; i++) begin
            ALU_busy = 1'b1;
            ex("mul_e2_busy", 10'h100, 10'h020, 3'b100, 6'b0);
        end
        ALU_busy = 1'b0;
        ex("mul_e3_lo", 10'h008, 10'h080, 3'b000, 6'b0);
        ex("mul_e4_hi", 10'h004, 10'h040, 3'b000, 6'b0);

        for (int k = 0; k < 2; k++) begin
            Con_ff = (k == 1);
            fetch("br", 5'b10011, 0);
            ex("br_e1", 10'h100, 10'h000, 3'b001, 6'b001000);
            ex("br_e2", 10'h001, 10'h010, 3'b000, 6'b0);
            ex("br_e3", 10'h080, 10'h020, 3'b000, 6'b0);
            ex(k ? "br_e4_taken" : "br_e4_not", k ? 10'h008 : 10'h000, k ? 10'h008 : 10'h000, 3'b000, 6'b0);
        end
        Con_ff = 1'b0;

        fetch("jal", 5'b10101, 0);
        tick();
        push("jal_e1", mk(10'h001, 0, 0, 0, 1'b1, 1'b0, 2'b00), 1, 16'h4000);
        ex("jal_e2", 10'h100, 10'h008, 3'b001, 6'b0);

        fetch("add2", 5'b00011, 0);
        Stop = 1'b1;
        ex("add2_e1", 10'h100, 10'h010, 3'b010, 6'b0);
        Stop = 1'b0;
        ex("add2_e2", 10'h100, 10'h020, 3'b100, 6'b0);
        ex("add2_e3", 10'h008, 10'h100, 3'b001, 6'b0);
        tick();
        push("halt", mk(0, 0, 0, 0, 1'b0, 1'b0, 2'b00));
        Resume = 1'b1; Stop = 1'b1;
        tick();
        push("halt_stop_wins", mk(0, 0, 0, 0, 1'b0, 1'b0, 2'b00));
        Stop = 1'b0;
        fetch("st", 5'b00010, 0);
        Resume = 1'b0;
        ex("st_e1", 10'h200, 10'h010, 3'b010, 6'b0);
        ex("st_e2", 10'h080, 10'h020, 3'b000, 6'b0);
        ex("st_e3", 10'h008, 10'h001, 3'b000, 6'b0);
        ex("st_e4", 10'h100, 10'h002, 3'b001, 6'b0);
        ex("st_e5", 10'h000, 10'h000, 3'b000, 6'b000011);

        fetch("st2", 5'b00010, 0);
        ex("st2_e1", 10'h200, 10'h010, 3'b010, 6'b0);
        ex("st2_e2", 10'h080, 10'h020, 3'b000, 6'b0);
        ex("st2_e3", 10'h008, 10'h001, 3'b000, 6'b0);
        ex("st2_e4", 10'h100, 10'h002, 3'b001, 6'b0);
        Reset = 1'b0;
        tick();
        push("st2_reset", mk(0, 0, 0, 0, 1'b0, 1'b0, 2'b00), 0, 0, 1, 0);
        exp_cnt = 0;
        Reset = 1'b1;

        fetch("ill", 5'b11101, 0);
        tick();
        push("ill_trap", mk(0, 0, 0, 0, 1'b0, 1'b1, 2'b01), 0, 0, 1, 1);
        tick();
        push("ill_trap_hold", mk(0, 0, 0, 0, 1'b0, 1'b1, 2'b01));
        Reset = 1'b0;
        tick();
        push("ill_reset", mk(0, 0, 0, 0, 1'b0, 1'b0, 2'b00), 0, 0, 1, 0);
        Reset = 1'b1;

        Mem_ready = 1'b0;
        ex("to_f0", 10'h001, 10'h001, 3'b000, 6'b0);
        for (int i = 0; i < 16; i++) ex("to_f1", 10'h000, 10'h002, 3'b000, 6'b100010);
        tick();
        push("to_trap", mk(0, 0, 0, 0, 1'b0, 1'b1, 2'b10));
        Reset = 1'b0;
        tick();
        push("to_reset", mk(0, 0, 0, 0, 1'b0, 1'b0, 2'b00));
        Reset = 1'b1;
        ex("to_after_f0", 10'h001, 10'h001, 3'b000, 6'b0);

        tick(); tick();
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end
endmodule
